// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the execute stage: ALU op codes, main-control aluop encodings,
// R-type funct values and status flag bit positions.
package alu_exec_unit_pkg;

  typedef logic [2:0] alu_ctrl_t;
  typedef logic [1:0] aluop_t;
  typedef logic [4:0] funct_t;

  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_NOR = 3'b100;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_SLT = 3'b111;

  localparam aluop_t ALUOP_MEM   = 2'b00;
  localparam aluop_t ALUOP_BEQ   = 2'b01;
  localparam aluop_t ALUOP_RTYPE = 2'b10;
  localparam aluop_t ALUOP_ADDI  = 2'b11;

  localparam funct_t FUNCT_ADD = 5'b00000;
  localparam funct_t FUNCT_SUB = 5'b00010;
  localparam funct_t FUNCT_AND = 5'b00100;
  localparam funct_t FUNCT_OR  = 5'b00101;
  localparam funct_t FUNCT_NOR = 5'b00111;
  localparam funct_t FUNCT_SLT = 5'b01010;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_V = 2;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the decode stage (master) and the execute unit (slave).
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       aluop;
  logic [4:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm_sext;
  logic             status_we;
  logic [2:0]       gout;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [2:0]       status;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output aluop, funct, a, b, pc, imm_sext, status_we,
    input  gout, result, zero, status, status_q, pc_plus4, branch_target
  );

  modport slave (
    input  aluop, funct, a, b, pc, imm_sext, status_we,
    output gout, result, zero, status, status_q, pc_plus4, branch_target
  );
endinterface

// File: rtl/alu_exec_unit_adder.sv
// Plain WIDTH-bit wrapping adder, shared by the PC incrementer and branch-target path.
module alu_exec_unit_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/alu_op_decode.sv
// ALU-control decode: maps main-control aluop and the funct field to the ALU op code.
module alu_op_decode
  import alu_exec_unit_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [4:0] funct_i,
  output logic [2:0] gout_o
);

  always_comb begin
    gout_o = ALU_ADD;
    case (aluop_i)
      ALUOP_BEQ: gout_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_SUB: gout_o = ALU_SUB;
          FUNCT_AND: gout_o = ALU_AND;
          FUNCT_OR:  gout_o = ALU_OR;
          FUNCT_NOR: gout_o = ALU_NOR;
          FUNCT_SLT: gout_o = ALU_SLT;
          default:   gout_o = ALU_ADD;
        endcase
      end
      default: gout_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, ALU with {V,N,Z} flags, PC+4 and branch-target adders,
// and the architectural status register read by the flag-conditional branches.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [2:0]       gout;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             v_add;
  logic             v_sub;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [2:0]       status;
  logic [2:0]       status_d;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] imm_shift;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;

  alu_op_decode u_decode (
    .aluop_i (bus.aluop),
    .funct_i (bus.funct),
    .gout_o  (gout)
  );

  assign sum   = bus.a + bus.b;
  assign diff  = bus.a - bus.b;
  assign v_add = (bus.a[Msb] == bus.b[Msb]) && (sum[Msb] != bus.a[Msb]);
  assign v_sub = (bus.a[Msb] != bus.b[Msb]) && (diff[Msb] != bus.a[Msb]);
  // Sign of the difference corrected by overflow gives a true signed compare at the extremes.
  assign slt   = diff[Msb] ^ v_sub;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (gout)
      ALU_AND: alu_res = bus.a & bus.b;
      ALU_OR:  alu_res = bus.a | bus.b;
      ALU_NOR: alu_res = ~(bus.a | bus.b);
      ALU_ADD: begin
        alu_res = sum;
        alu_v   = v_add;
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_v   = v_sub;
      end
      ALU_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, slt};
        alu_v   = v_sub;
      end
      default: begin
        alu_res = '0;
        alu_v   = 1'b0;
      end
    endcase
  end

  always_comb begin
    status        = '0;
    status[FLG_Z] = (alu_res == '0);
    status[FLG_N] = alu_res[Msb];
    status[FLG_V] = alu_v;
  end

  assign status_d = bus.status_we ? status : status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 3'b000;
    end else begin
      status_q <= status_d;
    end
  end

  assign pc_inc    = WIDTH'(PC_INC);
  assign imm_shift = {bus.imm_sext[WIDTH-3:0], 2'b00};

  alu_exec_unit_adder #(
    .WIDTH (WIDTH)
  ) u_pc_inc (
    .a_i   (bus.pc),
    .b_i   (pc_inc),
    .sum_o (pc_plus4)
  );

  alu_exec_unit_adder #(
    .WIDTH (WIDTH)
  ) u_br_tgt (
    .a_i   (pc_plus4),
    .b_i   (imm_shift),
    .sum_o (branch_target)
  );

  assign bus.gout          = gout;
  assign bus.result        = alu_res;
  assign bus.zero          = status[FLG_Z];
  assign bus.status        = status;
  assign bus.status_q      = status_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.branch_target = branch_target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Table-driven check of the execute stage plus hand sequences for the status register.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(
    .WIDTH  (32),
    .PC_INC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [4:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  status;
    logic [31:0] pc4;
    logic [31:0] bt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] aluop, input logic [4:0] funct,
                       input logic [31:0] a, input logic [31:0] b);
    bus.aluop = aluop;
    bus.funct = funct;
    bus.a     = a;
    bus.b     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //          aluop  funct     a             b             pc            imm           gout    result        z     status  pc4           bt
    vecs[0]  = '{2'b10, 5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h0000001C, 32'hFFFFFFFE, 3'b010, 32'h80000000, 1'b0, 3'b110, 32'h00000020, 32'h00000018};
    vecs[1]  = '{2'b01, 5'b10101, 32'h00000005, 32'h00000005, 32'hFFFFFFFC, 32'h00000000, 3'b110, 32'h00000000, 1'b1, 3'b001, 32'h00000000, 32'h00000000};
    vecs[2]  = '{2'b10, 5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000003, 3'b111, 32'h00000001, 1'b0, 3'b000, 32'h00000104, 32'h00000110};
    vecs[3]  = '{2'b10, 5'b01010, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 3'b111, 32'h00000001, 1'b0, 3'b100, 32'h00000004, 32'h00000004};
    vecs[4]  = '{2'b10, 5'b01010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000, 3'b111, 32'h00000000, 1'b1, 3'b101, 32'h00000004, 32'h00000004};
    vecs[5]  = '{2'b10, 5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'h00000000, 3'b000, 32'h00F000F0, 1'b0, 3'b000, 32'h00000004, 32'h00000004};
    vecs[6]  = '{2'b10, 5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'h00000000, 3'b001, 32'hFFF0FFF0, 1'b0, 3'b010, 32'h00000004, 32'h00000004};
    vecs[7]  = '{2'b10, 5'b00111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'h00000000, 3'b100, 32'h000F000F, 1'b0, 3'b000, 32'h00000004, 32'h00000004};
    vecs[8]  = '{2'b00, 5'b00111, 32'h00000003, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 3'b010, 32'h00000002, 1'b0, 3'b000, 32'h00000004, 32'h00000004};
    vecs[9]  = '{2'b11, 5'b00010, 32'h00000010, 32'h00000020, 32'h00000000, 32'h00000000, 3'b010, 32'h00000030, 1'b0, 3'b000, 32'h00000004, 32'h00000004};
    vecs[10] = '{2'b10, 5'b00010, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 3'b110, 32'hFFFFFFFF, 1'b0, 3'b010, 32'h00000004, 32'h00000004};
    vecs[11] = '{2'b10, 5'b11111, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 3'b010, 32'h00000002, 1'b0, 3'b000, 32'h00000004, 32'h00000004};
    vecs[12] = '{2'b10, 5'b00010, 32'h80000000, 32'h00000001, 32'h00000000, 32'h00000000, 3'b110, 32'h7FFFFFFF, 1'b0, 3'b100, 32'h00000004, 32'h00000004};
    vecs[13] = '{2'b10, 5'b00000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 3'b010, 32'h00000000, 1'b1, 3'b101, 32'h00000004, 32'h00000004};

    rst_n         = 1'b0;
    bus.status_we = 1'b0;
    bus.pc        = '0;
    bus.imm_sext  = '0;
    drive(2'b00, 5'b00000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset status_q", {29'd0, bus.status_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
      bus.pc       = vecs[i].pc;
      bus.imm_sext = vecs[i].imm;
      #1;
      check($sformatf("v%0d gout", i),   {29'd0, bus.gout},   {29'd0, vecs[i].gout});
      check($sformatf("v%0d result", i), bus.result,          vecs[i].result);
      check($sformatf("v%0d zero", i),   {31'd0, bus.zero},   {31'd0, vecs[i].zero});
      check($sformatf("v%0d status", i), {29'd0, bus.status}, {29'd0, vecs[i].status});
      check($sformatf("v%0d pc_plus4", i), bus.pc_plus4,      vecs[i].pc4);
      check($sformatf("v%0d br_target", i), bus.branch_target, vecs[i].bt);
    end
    check("status_q untouched while we=0", {29'd0, bus.status_q}, 32'h0);

    // Latch V,N from overflowing add.
    @(negedge clk);
    drive(2'b10, 5'b00000, 32'h7FFFFFFF, 32'h00000001);
    bus.status_we = 1'b1;
    @(posedge clk);
    #1;
    check("latch status_q=110", {29'd0, bus.status_q}, 32'h6);

    // Hold across edges with we low while the live flags differ.
    @(negedge clk);
    bus.status_we = 1'b0;
    drive(2'b01, 5'b00000, 32'h5, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    check("hold status_q", {29'd0, bus.status_q}, 32'h6);
    check("live status differs", {29'd0, bus.status}, 32'h1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async clear before edge", {29'd0, bus.status_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latch Z, then reset overrides a pending write.
    bus.status_we = 1'b1;
    @(posedge clk);
    #1;
    check("latch status_q=001", {29'd0, bus.status_q}, 32'h1);
    @(negedge clk);
    drive(2'b10, 5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset overrides we", {29'd0, bus.status_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("latch N after reset", {29'd0, bus.status_q}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
